// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: round-robin packet grant held from head to tail flit.
// Optional per-input tail counters on pkt_count_o when ARB_PKT_STATS_EN is defined.
module noc_output_arbiter #(
    parameter int unsigned N_IN       = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_IN*DATA_WIDTH-1:0] in_data_i,
    input  logic [N_IN-1:0]            in_valid_i,
    output logic [N_IN-1:0]            in_ready_o,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N_IN-1:0]            grant_o,
`ifdef ARB_PKT_STATS_EN
    output logic [N_IN*16-1:0]         pkt_count_o,
`endif
    output logic                       busy_o
);
    localparam int unsigned IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [1:0]  FLIT_HEAD = 2'd1;
    localparam logic [1:0]  FLIT_TAIL = 2'd3;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [N_IN-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [DATA_WIDTH-1:0] in_flit [N_IN];
    logic [N_IN-1:0]       req;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      cand;
    logic                  tail_hs;

    // Only a valid head flit counts as a request for the output.
    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign in_flit[i] = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign req[i]     = in_valid_i[i] && (in_flit[i][DATA_WIDTH-1 -: 2] == FLIT_HEAD);
    end

    assign tail_hs = out_valid_o && out_ready_i && (out_data_o[DATA_WIDTH-1 -: 2] == FLIT_TAIL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(N_IN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Round-robin scan starts one past the last packet's owner.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N_IN);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = N_IN'(1) << pick_idx;
                    owner_d = pick_idx;
                end
            end
            LOCKED: begin
                if (tail_hs) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner's flits pass straight through so a locked packet adds no latency.
    always_comb begin
        in_ready_o  = '0;
        out_data_o  = '0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        if (state_q == LOCKED) begin
            out_data_o          = in_flit[owner_q];
            out_valid_o         = in_valid_i[owner_q];
            in_ready_o[owner_q] = out_ready_i;
            busy_o              = 1'b1;
        end
    end

    assign grant_o = grant_q;

`ifdef ARB_PKT_STATS_EN
    logic [N_IN-1:0][15:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (tail_hs && (owner_q == IDX_W'(i)) && (pkt_cnt_q[i] != 16'hFFFF)) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign pkt_count_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: vector table, directed sequences, random traffic vs reference model.
`timescale 1ns/1ps
module tb_noc_output_arbiter;
    localparam int N = 5;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;
`ifdef ARB_PKT_STATS_EN
    logic [N*16-1:0] pkt_count;
`endif

    noc_output_arbiter #(.N_IN(N), .DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .grant_o    (grant),
`ifdef ARB_PKT_STATS_EN
        .pkt_count_o(pkt_count),
`endif
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] vld;
        int           src;
        logic [W-1:0] dat;
        logic [N-1:0] e_grant;
        logic         e_busy;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [N-1:0] e_rdy;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] srcq [N][$];
    int           m_owner;
    int           m_ptr;
    int           m_tails [N];
    int           m_acc [N];
    int           n_in;
    int           n_out;
    int           gap_pct;
    int           ordy_pct;
    logic         ordy_plan [$];
    logic [N-1:0] prev_grant;
    int           dut_order [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] vld, input int src, input logic [W-1:0] dat,
                                input logic [N-1:0] eg, input logic eb, input logic eov,
                                input logic [W-1:0] eod, input logic [N-1:0] er);
        vec_t v;
        v.vld = vld; v.src = src; v.dat = dat;
        v.e_grant = eg; v.e_busy = eb; v.e_ov = eov; v.e_od = eod; v.e_rdy = er;
        return v;
    endfunction

    task automatic load_pkt(input int src, input int nbody);
        logic [W-1:0] f;
        int t;
        f = {2'd1, 30'($urandom)};
        srcq[src].push_back(f);
        for (int b = 0; b < nbody; b++) begin
            t = int'($urandom_range(2));
            f = {(t == 0) ? 2'd2 : (t == 1) ? 2'd0 : 2'd1, 30'($urandom)};
            srcq[src].push_back(f);
        end
        f = {2'd3, 30'($urandom)};
        srcq[src].push_back(f);
        n_in += nbody + 2;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
            in_valid[i] = (srcq[i].size() > 0) && (int'($urandom_range(99)) >= gap_pct);
        end
        if (ordy_plan.size() > 0) out_ready = ordy_plan.pop_front();
        else out_ready = (int'($urandom_range(99)) < ordy_pct);
    endtask

    task automatic check_stats();
`ifdef ARB_PKT_STATS_EN
        for (int i = 0; i < N; i++)
            chk($sformatf("pkt_count_%0d", i), 64'(pkt_count[i*16 +: 16]), 64'(m_tails[i]));
`endif
    endtask

    // Reference: one owner or none; the owner's flits pass through until a tail is taken.
    task automatic step();
        logic [N-1:0] e_grant, e_rdy;
        logic         e_busy, e_ov;
        logic [W-1:0] e_od;
        int           j;
        @(negedge clk);
        e_grant = '0; e_rdy = '0; e_busy = 1'b0; e_ov = 1'b0; e_od = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_busy = 1'b1;
            e_ov   = in_valid[m_owner];
            e_od   = in_data[m_owner*W +: W];
            e_rdy[m_owner] = out_ready;
        end
        chk("grant", 64'(grant), 64'(e_grant));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        if (m_owner >= 0) chk("out_data", 64'(out_data), 64'(e_od));
        if (grant !== '0 && grant !== prev_grant) dut_order.push_back(oh_idx(grant));
        prev_grant = grant;
        if (out_valid === 1'b1 && out_ready) n_out++;
        if (m_owner >= 0) begin
            if (e_ov && out_ready) begin
                m_acc[m_owner]++;
                void'(srcq[m_owner].pop_front());
                if (e_od[W-1 -: 2] == 2'd3) begin
                    if (m_tails[m_owner] < 65535) m_tails[m_owner]++;
                    m_ptr   = m_owner;
                    m_owner = -1;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (m_owner < 0 && in_valid[j] && in_data[j*W + W - 1 -: 2] == 2'd1) m_owner = j;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (c < budget && !(all_empty() && m_owner < 0)) begin
            step();
            c++;
        end
        chk({name, "_done"}, 64'(c < budget), 64'd1);
        step();
        chk({name, "_flits"}, 64'(n_out), 64'(n_in));
    endtask

    task automatic check_order(input string name, input int exp[$]);
        chk({name, "_n"}, 64'(dut_order.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_order.size(); i++)
            chk($sformatf("%s_%0d", name, i), 64'(dut_order[i]), 64'(exp[i]));
        dut_order.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        #1;
        chk_zero(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero({tag, "_held"});
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            m_tails[i] = 0;
            m_acc[i] = 0;
        end
        check_stats();
        m_owner = -1; m_ptr = N - 1; n_in = 0; n_out = 0;
        prev_grant = '0;
        dut_order.delete();
        ordy_plan.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   e[$];
        int   c;

        gap_pct = 0;
        ordy_pct = 100;
        in_valid = '0; in_data = '0; out_ready = 1'b1;

        // Body flit while idle is ignored; then one full packet from input 0.
        tbl[0] = mk(5'b01000, 3, 32'h8000_0001, 5'b0,     1'b0, 1'b0, 32'h0,         5'b0);
        tbl[1] = mk(5'b01000, 3, 32'h8000_0001, 5'b0,     1'b0, 1'b0, 32'h0,         5'b0);
        tbl[2] = mk(5'b00001, 0, 32'h4000_0007, 5'b0,     1'b0, 1'b0, 32'h0,         5'b0);
        tbl[3] = mk(5'b00001, 0, 32'h4000_0007, 5'b00001, 1'b1, 1'b1, 32'h4000_0007, 5'b00001);
        tbl[4] = mk(5'b00001, 0, 32'h8000_0012, 5'b00001, 1'b1, 1'b1, 32'h8000_0012, 5'b00001);
        tbl[5] = mk(5'b00001, 0, 32'h8000_0013, 5'b00001, 1'b1, 1'b1, 32'h8000_0013, 5'b00001);
        tbl[6] = mk(5'b00001, 0, 32'h8000_0014, 5'b00001, 1'b1, 1'b1, 32'h8000_0014, 5'b00001);
        tbl[7] = mk(5'b00001, 0, 32'h8000_0015, 5'b00001, 1'b1, 1'b1, 32'h8000_0015, 5'b00001);
        tbl[8] = mk(5'b00001, 0, 32'hC000_0016, 5'b00001, 1'b1, 1'b1, 32'hC000_0016, 5'b00001);
        tbl[9] = mk(5'b00000, 0, 32'h0,         5'b0,     1'b0, 1'b0, 32'h0,         5'b0);

        do_reset("rst0");
        for (int r = 0; r < 10; r++) begin
            in_valid = tbl[r].vld;
            in_data = '0;
            in_data[tbl[r].src*W +: W] = tbl[r].dat;
            out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("t1_r%0d_grant", r), 64'(grant), 64'(tbl[r].e_grant));
            chk($sformatf("t1_r%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
            chk($sformatf("t1_r%0d_out_valid", r), 64'(out_valid), 64'(tbl[r].e_ov));
            chk($sformatf("t1_r%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].e_rdy));
            if (tbl[r].e_ov) chk($sformatf("t1_r%0d_out_data", r), 64'(out_data), 64'(tbl[r].e_od));
            @(posedge clk);
            #1;
        end

        // Contention 1 vs 3 from ptr=4, then 2 vs 4 confirms ptr landed on 3.
        do_reset("rst_t2");
        load_pkt(1, 1);
        load_pkt(3, 0);
        drain("t2a", 100);
        e = '{1, 3};
        check_order("t2a_order", e);
        load_pkt(2, 1);
        load_pkt(4, 1);
        drain("t2b", 100);
        e = '{4, 2};
        check_order("t2b_order", e);

        // Fairness between two streaming inputs.
        do_reset("rst_t3");
        for (int p = 0; p < 3; p++) begin
            load_pkt(0, int'($urandom_range(3)));
            load_pkt(2, int'($urandom_range(3)));
        end
        drain("t3", 200);
        e = '{0, 2, 0, 2, 0, 2};
        check_order("t3_order", e);

        // Backpressure for 4 cycles mid-packet.
        do_reset("rst_t4");
        load_pkt(1, 4);
        ordy_plan = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        drain("t4", 100);
        e = '{1};
        check_order("t4_order", e);

        // Asynchronous reset after the third flit, then a fresh packet on input 2.
        do_reset("rst_t5a");
        load_pkt(0, 4);
        c = 0;
        while (m_acc[0] < 3 && c < 20) begin
            step();
            c++;
        end
        chk("t5_reach", 64'(m_acc[0] >= 3), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async");
        @(posedge clk);
        @(negedge clk);
        chk("t5_no_accept", 64'(in_ready), 64'd0);
        do_reset("rst_t5b");
        load_pkt(2, 2);
        drain("t5", 100);
        e = '{2};
        check_order("t5_order", e);

        // Two packets from input 4 for the counters.
        do_reset("rst_t6");
        load_pkt(4, 1);
        load_pkt(4, 2);
        drain("t6", 100);
        check_stats();
        e = '{4, 4};
        check_order("t6_order", e);

        // Random traffic with valid gaps and downstream stalls.
        do_reset("rst_rand");
        gap_pct = 25;
        ordy_pct = 70;
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 6; p++) load_pkt(i, int'($urandom_range(4)));
        drain("rand", 6000);
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
